axis_pkt_arbiter: RTL and testbench
===================================

// Module: axis_pkt_arbiter
// PURPOSE
//  Packet-level round-robin arbiter that shares one NoC injection port between
//  N_PORTS AXI-Stream traffic sources (e.g. number-generator instances).
//  Grant is locked from first beat until the TLAST beat is accepted.
//  Output goes through a single register stage. TID is rewritten to the source index.
// PARAMETERS
//  N_PORTS  4   number of requesting AXI-Stream slave ports (>=2)
//  TDATAW   32  tdata width
//  TDESTW   4   tdest width
//  TIDW     2   tid width; must be >= $clog2(N_PORTS)
// PORTS
//  CLK            in   1                clock
//  RST_N          in   1                reset, synchronous, active-low
//  AXIS_S_TVALID  in   N_PORTS          per-port valid
//  AXIS_S_TREADY  out  N_PORTS          per-port ready
//  AXIS_S_TDATA   in   N_PORTS*TDATAW   port p at [p*TDATAW +: TDATAW]
//  AXIS_S_TLAST   in   N_PORTS          per-port last
//  AXIS_S_TDEST   in   N_PORTS*TDESTW   port p at [p*TDESTW +: TDESTW]
//  AXIS_M_TVALID  out  1                output valid (registered)
//  AXIS_M_TREADY  in   1                output ready
//  AXIS_M_TDATA   out  TDATAW           output data (registered)
//  AXIS_M_TLAST   out  1                output last (registered)
//  AXIS_M_TID     out  TIDW             index of source port, zero-extended
//  AXIS_M_TDEST   out  TDESTW           output dest (registered)
//  GRANT          out  $clog2(N_PORTS)  currently/last granted port index
//  BUSY           out  1                1 while in LOCKED
// BEHAVIOUR
//  Reset (RST_N==0 at a CLK edge): state=IDLE, AXIS_M_TVALID/TLAST/TDATA/TID/TDEST=0.
//   GRANT=N_PORTS-1 (so port 0 has first priority) and BUSY=0. In-flight beats are dropped.
//  FSM IDLE: AXIS_S_TREADY=0 on all ports. If any S_TVALID is set, pick the first valid
//   port searching from GRANT+1 upward mod N_PORTS. GRANT<=pick, go to LOCKED.
//   With no valid port, stay in IDLE and hold GRANT.
//  FSM LOCKED: AXIS_S_TREADY[GRANT] = !AXIS_M_TVALID || AXIS_M_TREADY. All other readies are 0.
//   A beat is accepted on S_TVALID[GRANT] && S_TREADY[GRANT]. The accepted beat loads the
//   output regs next edge: TDATA/TDEST/TLAST from GRANT's slice, TID=GRANT, M_TVALID=1.
//   Accepting a TLAST beat returns the FSM to IDLE on the same edge (GRANT is kept).
//  Output reg: if no beat is accepted and M_TREADY=1, M_TVALID<=0. Simultaneous drain and
//   accept: the new beat replaces the old one (full throughput, 1 beat/cycle).
//  M_TDATA/TDEST/TLAST/TID hold stable while M_TVALID && !M_TREADY (AXIS rule).
//  Latency: S_TVALID seen in IDLE at edge t -> LOCKED at t+1 -> first beat on M at t+2.
//   Each back-to-back packet costs one IDLE bubble cycle.
//  Ungranted ports may hold or drop TVALID freely. The arbiter never splits a packet.
//  Request pattern does not affect a locked grant, so there is no preemption.
//  Source AXIS_S_TID is not an input. Output TID always equals the source index.
//  Fairness: a port whose TVALID stays high is granted within N_PORTS packets.
// TESTING
//  1 Ports 0,1 both send a 3-beat pkt (A0..A2, B0..B2) from reset, M_TREADY=1.
//    -> M sees A0,A1,A2(TLAST,TID=0), then after 1 bubble B0..B2(TLAST,TID=1).
//  2 Port 2 only, 1-beat pkt 0x55, dest 1. -> M_TVALID rises 2 cycles after S_TVALID,
//    TDATA=0x00000055, TDEST=1, TID=2, TLAST=1; then BUSY=0.
//  3 Port 0 sends 4 beats; M_TREADY low for 3 cycles after beat 1. -> beat 1 stays
//    stable on M, S_TREADY[0]=0, and no beat is lost or duplicated.
//  4 All 4 ports continuously valid with 2-beat pkts. -> grant order 0,1,2,3,0,...,
//    and no port is served twice before the others.
//  5 RST_N=0 for 1 cycle mid-packet on port 1. -> next cycle M_TVALID=0, BUSY=0,
//    GRANT=3, and the next request from port 0 is granted first.
//  6 Port 3 sends a pkt while port 1 raises TVALID mid-packet. -> port 3 pkt completes
//    uninterrupted, then port 1 (search starts at 0; port 0 idle).

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: N_PORTS AXI-Stream sources share one
// registered AXI-Stream master port. A grant is taken in IDLE and then held
// from the first beat until the TLAST beat is accepted, so packets never
// interleave. The output TID carries the index of the source port.
//
// Handshake: a beat moves on any interface only on a clock edge where both
// TVALID and TREADY are high. A source may not retract TVALID or change its
// payload while TVALID is high and TREADY is low. The master side follows the
// same rule: TDATA/TDEST/TLAST/TID hold while TVALID && !TREADY.
module axis_pkt_arbiter #(
    parameter int N_PORTS = 4,
    parameter int TDATAW  = 32,
    parameter int TDESTW  = 4,
    parameter int TIDW    = 2
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [N_PORTS-1:0]           AXIS_S_TVALID,
    output logic [N_PORTS-1:0]           AXIS_S_TREADY,
    input  logic [N_PORTS*TDATAW-1:0]    AXIS_S_TDATA,
    input  logic [N_PORTS-1:0]           AXIS_S_TLAST,
    input  logic [N_PORTS*TDESTW-1:0]    AXIS_S_TDEST,
    output logic                         AXIS_M_TVALID,
    input  logic                         AXIS_M_TREADY,
    output logic [TDATAW-1:0]            AXIS_M_TDATA,
    output logic                         AXIS_M_TLAST,
    output logic [TIDW-1:0]              AXIS_M_TID,
    output logic [TDESTW-1:0]            AXIS_M_TDEST,
    output logic [$clog2(N_PORTS)-1:0]   GRANT,
    output logic                         BUSY
);

    localparam int GW = $clog2(N_PORTS);

    // BUSY mirrors the state register, so the FSM state is visible externally.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q,   state_d;
    logic [GW-1:0]       grant_q,   grant_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q,  m_last_d;
    logic [TDATAW-1:0]   m_data_q,  m_data_d;
    logic [TDESTW-1:0]   m_dest_q,  m_dest_d;
    logic [TIDW-1:0]     m_id_q,    m_id_d;

    logic [N_PORTS-1:0]  s_tready;
    logic                slot_free;
    logic                accept;

    logic [TDATAW-1:0]   s_data [N_PORTS];
    logic [TDESTW-1:0]   s_dest [N_PORTS];

    // Round-robin search: first requesting port strictly after 'last', wrapping.
    // If nothing requests, 'last' is returned unchanged.
    function automatic logic [GW-1:0] next_pick(input logic [GW-1:0]      last,
                                                input logic [N_PORTS-1:0] req);
        logic [GW-1:0] pick;
        logic [GW-1:0] idx;
        logic          found;
        int            cand;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = (int'(last) + i) % N_PORTS;
            idx  = GW'(cand);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    // Unpack the flattened per-port payload buses into arrays indexed by port.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            s_data[p] = AXIS_S_TDATA[p*TDATAW +: TDATAW];
            s_dest[p] = AXIS_S_TDEST[p*TDESTW +: TDESTW];
        end
    end

    // The output register can take a new beat when empty or draining this cycle.
    assign slot_free = !m_valid_q || AXIS_M_TREADY;

    // Next-state, per-port ready and output-register load logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        m_dest_d  = m_dest_q;
        m_id_d    = m_id_q;
        s_tready  = '0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|AXIS_S_TVALID) begin
                    grant_d = next_pick(grant_q, AXIS_S_TVALID);
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                s_tready[grant_q] = slot_free;
                accept            = AXIS_S_TVALID[grant_q] && slot_free;
                // Grant stays on this port; only the packet end releases it.
                if (accept && AXIS_S_TLAST[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new beat overwrites the register even while the old one drains.
        if (accept) begin
            m_valid_d = 1'b1;
            m_last_d  = AXIS_S_TLAST[grant_q];
            m_data_d  = s_data[grant_q];
            m_dest_d  = s_dest[grant_q];
            m_id_d    = TIDW'(grant_q);
        end else if (AXIS_M_TREADY) begin
            m_valid_d = 1'b0;
        end
    end

    // State, grant and output register; reset puts priority on port 0.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            grant_q   <= GW'(N_PORTS - 1);
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_dest_q  <= '0;
            m_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_dest_q  <= m_dest_d;
            m_id_q    <= m_id_d;
        end
    end

    assign AXIS_S_TREADY = s_tready;
    assign AXIS_M_TVALID = m_valid_q;
    assign AXIS_M_TLAST  = m_last_q;
    assign AXIS_M_TDATA  = m_data_q;
    assign AXIS_M_TDEST  = m_dest_q;
    assign AXIS_M_TID    = m_id_q;
    assign GRANT         = grant_q;
    assign BUSY          = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter: per-port packet sources fed from
// small beat tables, a monitor that logs every master-side transfer, and one
// task per scenario comparing the log against hand-written expected beats.
module tb_axis_pkt_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int DSW = 4;
    localparam int IW  = 2;
    localparam int GW  = 2;
    localparam int W   = IW + 1 + DSW + DW;   // {tid, last, dest, data}
    localparam int SW  = 1 + DSW + DW;        // {last, dest, data}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]     s_tvalid;
    logic [N-1:0]     s_tready;
    logic [N*DW-1:0]  s_tdata;
    logic [N-1:0]     s_tlast;
    logic [N*DSW-1:0] s_tdest;
    logic             m_tvalid;
    logic             m_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tlast;
    logic [IW-1:0]    m_tid;
    logic [DSW-1:0]   m_tdest;
    logic [GW-1:0]    grant;
    logic             busy;

    axis_pkt_arbiter #(
        .N_PORTS(N), .TDATAW(DW), .TDESTW(DSW), .TIDW(IW)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .AXIS_S_TVALID(s_tvalid),
        .AXIS_S_TREADY(s_tready),
        .AXIS_S_TDATA (s_tdata),
        .AXIS_S_TLAST (s_tlast),
        .AXIS_S_TDEST (s_tdest),
        .AXIS_M_TVALID(m_tvalid),
        .AXIS_M_TREADY(m_tready),
        .AXIS_M_TDATA (m_tdata),
        .AXIS_M_TLAST (m_tlast),
        .AXIS_M_TID   (m_tid),
        .AXIS_M_TDEST (m_tdest),
        .GRANT        (grant),
        .BUSY         (busy)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [SW-1:0] src_mem [N][16];
    int            src_len [N];
    int            src_ptr [N];
    logic          src_en  [N];

    logic [W-1:0]  obs_q[$];
    int            obs_cyc[$];
    logic [W-1:0]  exp_q[$];

    logic          snap_valid;
    logic [W-1:0]  snap_word;
    logic          snap_busy;
    logic [GW-1:0] snap_grant;
    logic [N-1:0]  snap_sready;

    function automatic logic [W-1:0] mk(input logic [IW-1:0] tid, input logic last,
                                        input logic [DSW-1:0] dest, input logic [DW-1:0] data);
        return {tid, last, dest, data};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_srcs();
        for (int p = 0; p < N; p++) begin
            if (src_en[p] && src_ptr[p] < src_len[p]) begin
                s_tvalid[p] = 1'b1;
                {s_tlast[p], s_tdest[p*DSW +: DSW], s_tdata[p*DW +: DW]} = src_mem[p][src_ptr[p]];
            end else begin
                s_tvalid[p] = 1'b0;
                s_tlast[p]  = 1'b0;
                s_tdest[p*DSW +: DSW] = '0;
                s_tdata[p*DW +: DW]   = '0;
            end
        end
    endtask

    task automatic clear_srcs();
        for (int p = 0; p < N; p++) begin
            src_len[p] = 0;
            src_ptr[p] = 0;
            src_en[p]  = 1'b0;
        end
    endtask

    task automatic load_pkt(input int p, input int nbeats, input logic [DW-1:0] base,
                            input logic [DSW-1:0] dest);
        for (int b = 0; b < nbeats; b++) begin
            src_mem[p][src_len[p]] = {(b == nbeats - 1), dest, base + DW'(b)};
            src_len[p] = src_len[p] + 1;
        end
    endtask

    // One clock: sample at negedge (snapshot + monitor), then advance sources.
    task automatic tick();
        logic [N-1:0] hs;
        @(negedge clk);
        snap_valid  = m_tvalid;
        snap_word   = {m_tid, m_tlast, m_tdest, m_tdata};
        snap_busy   = busy;
        snap_grant  = grant;
        snap_sready = s_tready;
        if (m_tvalid && m_tready) begin
            obs_q.push_back({m_tid, m_tlast, m_tdest, m_tdata});
            obs_cyc.push_back(cyc);
        end
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        for (int p = 0; p < N; p++) begin
            if (hs[p]) src_ptr[p] = src_ptr[p] + 1;
        end
        drive_srcs();
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (obs_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        m_tready = 1'b1;
        clear_srcs();
        drive_srcs();
        tick();
        tick();
        rst_n = 1'b1;
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (snap_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_tvalid: got %b expected 0", snap_valid);
        end
        n_tests++;
        if (snap_word !== '0) begin
            n_fail++; $display("FAIL reset_payload: got %h expected 0", snap_word);
        end
        n_tests++;
        if (snap_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", snap_busy);
        end
        n_tests++;
        if (snap_grant !== 2'd3) begin
            n_fail++; $display("FAIL reset_grant: got %0d expected 3", snap_grant);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        apply_reset();
        load_pkt(0, 3, 32'hA000_0000, 4'd3);
        load_pkt(1, 3, 32'hB000_0000, 4'd5);
        src_en[0] = 1'b1;
        src_en[1] = 1'b1;
        drive_srcs();
        exp_q.push_back(mk(2'd0, 1'b0, 4'd3, 32'hA000_0000));
        exp_q.push_back(mk(2'd0, 1'b0, 4'd3, 32'hA000_0001));
        exp_q.push_back(mk(2'd0, 1'b1, 4'd3, 32'hA000_0002));
        exp_q.push_back(mk(2'd1, 1'b0, 4'd5, 32'hB000_0000));
        exp_q.push_back(mk(2'd1, 1'b0, 4'd5, 32'hB000_0001));
        exp_q.push_back(mk(2'd1, 1'b1, 4'd5, 32'hB000_0002));
        wait_obs(6, 40, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL b2b_timeout: got %0d beats expected 6", obs_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (obs_cyc[2] - obs_cyc[0] !== 2) begin
            n_fail++; $display("FAIL b2b_pkt_a_span: got %0d expected 2", obs_cyc[2] - obs_cyc[0]);
        end
        n_tests++;
        if (obs_cyc[3] - obs_cyc[2] !== 2) begin
            n_fail++; $display("FAIL b2b_bubble: got %0d expected 2", obs_cyc[3] - obs_cyc[2]);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        load_pkt(2, 1, 32'h0000_0055, 4'd1);
        src_en[2] = 1'b1;
        drive_srcs();
        tick();
        tick();
        n_tests++;
        if (snap_valid !== 1'b0 || snap_busy !== 1'b1) begin
            n_fail++; $display("FAIL lat_locked: got valid=%b busy=%b expected valid=0 busy=1",
                               snap_valid, snap_busy);
        end
        n_tests++;
        if (snap_grant !== 2'd2) begin
            n_fail++; $display("FAIL lat_grant: got %0d expected 2", snap_grant);
        end
        tick();
        n_tests++;
        if (snap_valid !== 1'b1) begin
            n_fail++; $display("FAIL lat_tvalid: got %b expected 1", snap_valid);
        end
        n_tests++;
        if (snap_word !== mk(2'd2, 1'b1, 4'd1, 32'h0000_0055)) begin
            n_fail++; $display("FAIL lat_beat: got %h expected %h", snap_word,
                               mk(2'd2, 1'b1, 4'd1, 32'h0000_0055));
        end
        n_tests++;
        if (snap_busy !== 1'b0) begin
            n_fail++; $display("FAIL lat_busy_after: got %b expected 0", snap_busy);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [W-1:0] d1;
        apply_reset();
        load_pkt(0, 4, 32'hD000_0000, 4'd7);
        src_en[0] = 1'b1;
        drive_srcs();
        d1 = mk(2'd0, 1'b0, 4'd7, 32'hD000_0001);
        wait_obs(1, 20, ok);
        m_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (snap_valid !== 1'b1 || snap_word !== d1) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b %h expected v=1 %h",
                                   k, snap_valid, snap_word, d1);
            end
            n_tests++;
            if (snap_sready[0] !== 1'b0) begin
                n_fail++; $display("FAIL bp_sready%0d: got %b expected 0", k, snap_sready[0]);
            end
        end
        m_tready = 1'b1;
        wait_obs(4, 20, ok);
        tick();
        tick();
        tick();
        n_tests++;
        if (obs_q.size() !== 4) begin
            n_fail++; $display("FAIL bp_count: got %0d expected 4", obs_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs_q[i] !== mk(2'd0, (i == 3), 4'd7, 32'hD000_0000 + DW'(i))) begin
                n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", i, obs_q[i],
                                   mk(2'd0, (i == 3), 4'd7, 32'hD000_0000 + DW'(i)));
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        apply_reset();
        for (int pk = 0; pk < 2; pk++) begin
            for (int p = 0; p < N; p++) begin
                load_pkt(p, 2, DW'(p * 256 + pk * 128), DSW'(p + 8));
            end
        end
        for (int p = 0; p < N; p++) src_en[p] = 1'b1;
        drive_srcs();
        // Grant order 0,1,2,3,0,1,2,3 with each port's two packets in turn.
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 2; b++) begin
                exp_q.push_back(mk(IW'(k % 4), (b == 1), DSW'((k % 4) + 8),
                                   DW'((k % 4) * 256 + (k / 4) * 128 + b)));
            end
        end
        wait_obs(16, 100, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rr_timeout: got %0d beats expected 16", obs_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rr_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        apply_reset();
        load_pkt(1, 4, 32'hE100_0000, 4'd2);
        src_en[1] = 1'b1;
        drive_srcs();
        wait_obs(1, 20, ok);
        load_pkt(0, 1, 32'hE000_0000, 4'd9);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        src_en[0] = 1'b1;
        drive_srcs();
        obs_q.delete();
        obs_cyc.delete();
        tick();
        n_tests++;
        if (snap_valid !== 1'b0 || snap_busy !== 1'b0) begin
            n_fail++; $display("FAIL mrst_state: got valid=%b busy=%b expected 0 0",
                               snap_valid, snap_busy);
        end
        n_tests++;
        if (snap_grant !== 2'd3) begin
            n_fail++; $display("FAIL mrst_grant: got %0d expected 3", snap_grant);
        end
        wait_obs(1, 20, ok);
        n_tests++;
        if (obs_q[0] !== mk(2'd0, 1'b1, 4'd9, 32'hE000_0000)) begin
            n_fail++; $display("FAIL mrst_first: got %h expected %h", obs_q[0],
                               mk(2'd0, 1'b1, 4'd9, 32'hE000_0000));
        end
    endtask

    task automatic test_no_preempt();
        bit ok;
        apply_reset();
        load_pkt(3, 4, 32'hF300_0000, 4'd2);
        load_pkt(1, 2, 32'hF100_0000, 4'd4);
        src_en[3] = 1'b1;
        drive_srcs();
        wait_obs(2, 20, ok);
        src_en[1] = 1'b1;
        drive_srcs();
        for (int b = 0; b < 4; b++) exp_q.push_back(mk(2'd3, (b == 3), 4'd2, 32'hF300_0000 + DW'(b)));
        for (int b = 0; b < 2; b++) exp_q.push_back(mk(2'd1, (b == 1), 4'd4, 32'hF100_0000 + DW'(b)));
        wait_obs(6, 40, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL np_timeout: got %0d beats expected 6", obs_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL np_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_latency();
        test_backpressure();
        test_round_robin();
        test_mid_reset();
        test_no_preempt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
